alu_seq: RTL

- Parametrised, multi-cycle successor to the Gumnut single-cycle ALU.
- Same 12-op set, generalised to WIDTH bits.
- Registered outputs behind a valid/ready handshake.
- Shifts and rotates run iteratively, one bit per clock, so no barrel shifter is needed.
- Sits between decode/register-read and writeback. The core stalls on ready_o.

---
 rtl/alu_seq_pkg.sv | 31 +++
 rtl/alu_seq_shift1.sv | 22 ++
 rtl/alu_seq.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and decode helpers for the iterative ALU (alu_seq).
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_ADDC = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_SUBC = 4'b0011,
        OP_AND  = 4'b0100,
        OP_OR   = 4'b0101,
        OP_XOR  = 4'b0110,
        OP_ANDN = 4'b0111,
        OP_SHL  = 4'b1000,
        OP_SHR  = 4'b1001,
        OP_ROL  = 4'b1010,
        OP_ROR  = 4'b1011,
        OP_MUL  = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_MUL   = 2'd2
    } alu_state_e;

    // Shift/rotate opcodes share the 10xx prefix; bit 0 selects right, bit 1 selects rotate.
    function automatic logic is_shift_op(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/alu_seq_shift1.sv
// One-position shift/rotate step, iterated by the alu_seq FSM; returns {carry, value}.
module alu_seq_shift1
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic             dir_right,
    input  logic             rotate,
    output logic [WIDTH:0]   result
);

    // The bit that falls off the end becomes the carry; rotate feeds it back in, shift zero-fills.
    always_comb begin
        if (dir_right) begin
            result = {value[0], (rotate ? value[0] : 1'b0), value[WIDTH-1:1]};
        end else begin
            result = {value[WIDTH-1], value[WIDTH-2:0], (rotate ? value[WIDTH-1] : 1'b0)};
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshake: single-cycle arithmetic/logic, bit-serial shifts.
// Optional shift-add multiplier on opcode 1100 when ALU_SEQ_MUL_EN is defined.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       op_i,
    input  logic             carry_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] op2_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] res_o,
    output logic             carry_o,
    output logic             zero_o
);

    alu_state_e       state;
    logic [WIDTH-1:0] work;
    logic [CNT_W-1:0] cnt;
    logic             shift_right_q;
    logic             shift_rot_q;
    logic [WIDTH:0]   step;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             cin;
    logic [WIDTH-1:0] comb_res;
    logic             comb_carry;
    logic             start_shift;

    assign ready_o     = (state == ST_IDLE);
    assign start_shift = is_shift_op(op_i) && (count_i != '0);

    alu_seq_shift1 #(.WIDTH(WIDTH)) u_shift1 (
        .value     (work),
        .dir_right (shift_right_q),
        .rotate    (shift_rot_q),
        .result    (step)
    );

    // Single-cycle results; a zero-count shift/rotate passes rs_i through with no carry.
    always_comb begin
        cin        = op_i[0] ? carry_i : 1'b0;
        sum        = {1'b0, rs_i} + {1'b0, op2_i} + {{WIDTH{1'b0}}, cin};
        diff       = {1'b0, rs_i} - {1'b0, op2_i} - {{WIDTH{1'b0}}, cin};
        comb_res   = '0;
        comb_carry = 1'b0;
        case (alu_op_e'(op_i))
            OP_ADD, OP_ADDC: {comb_carry, comb_res} = sum;
            OP_SUB, OP_SUBC: {comb_carry, comb_res} = diff;
            OP_AND:          comb_res = rs_i & op2_i;
            OP_OR:           comb_res = rs_i | op2_i;
            OP_XOR:          comb_res = rs_i ^ op2_i;
            OP_ANDN:         comb_res = rs_i & ~op2_i;
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: comb_res = rs_i;
            default: begin
                comb_res   = '0;
                comb_carry = 1'b0;
            end
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W:0]     mul_cnt;
    logic               start_mul;

    assign start_mul = (op_i == OP_MUL);
    assign acc_next  = acc + (mplier[0] ? mcand : '0);

    // Shift-add: one partial product per cycle, multiplicand walks left as multiplier walks right.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            mul_cnt <= '0;
        end else if (state == ST_IDLE && valid_i && start_mul) begin
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, rs_i};
            mplier  <= op2_i;
            mul_cnt <= (CNT_W+1)'(WIDTH);
        end else if (state == ST_MUL) begin
            acc     <= acc_next;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            mul_cnt <= mul_cnt - 1'b1;
        end
    end
`endif

    // Output registers only move on a completion or reset; valid_o is a one-cycle pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state         <= ST_IDLE;
            valid_o       <= 1'b0;
            res_o         <= '0;
            carry_o       <= 1'b0;
            zero_o        <= 1'b1;
            work          <= '0;
            cnt           <= '0;
            shift_right_q <= 1'b0;
            shift_rot_q   <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (valid_i) begin
                        work          <= rs_i;
                        cnt           <= count_i;
                        shift_right_q <= op_i[0];
                        shift_rot_q   <= op_i[1];
                        if (start_shift) begin
                            state <= ST_SHIFT;
`ifdef ALU_SEQ_MUL_EN
                        end else if (start_mul) begin
                            state <= ST_MUL;
`endif
                        end else begin
                            res_o   <= comb_res;
                            carry_o <= comb_carry;
                            zero_o  <= (comb_res == '0);
                            valid_o <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    work <= step[WIDTH-1:0];
                    if (cnt == CNT_W'(1)) begin
                        res_o   <= step[WIDTH-1:0];
                        carry_o <= step[WIDTH];
                        zero_o  <= (step[WIDTH-1:0] == '0);
                        valid_o <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                ST_MUL: begin
                    if (mul_cnt == (CNT_W+1)'(1)) begin
                        res_o   <= acc_next[WIDTH-1:0];
                        carry_o <= |acc_next[2*WIDTH-1:WIDTH];
                        zero_o  <= (acc_next[WIDTH-1:0] == '0);
                        valid_o <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
